// File: rtl/pcihellocore_button_pkg.sv
// pcihellocore_button_pkg
//   Shared constants for the push-button/switch controller:
//   register word offsets, prescaler width and debounce history length.
package pcihellocore_button_pkg;

  localparam int PERIOD_W = 16;
  localparam int HIST_LEN = 3;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_MASK   = 2'd2;
  localparam logic [1:0] ADDR_EDGE   = 2'd3;

endpackage

// File: rtl/pcihellocore_button_debounce.sv
// pcihellocore_button_debounce
//   One input bit: two-flop synchronizer, tick-sampled history and the
//   debounced level.
//   clk_i   : system clock
//   reset_i : synchronous active-high reset
//   tick_i  : sample strobe from the shared prescaler
//   in_i    : raw asynchronous input bit
//   db_o    : debounced level
//   chg_o   : high in the cycle whose clock edge changes db_o
module pcihellocore_button_debounce
  import pcihellocore_button_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic tick_i,
  input  logic in_i,
  output logic db_o,
  output logic chg_o
);

  logic [1:0]          sync_q;
  logic [HIST_LEN-1:0] hist_q, hist_d;
  logic                db_q, db_d;

  // The debounced level is decided from the history as it will be after this
  // tick, so the level moves on the same edge that completes a stable run.
  always_comb begin
    hist_d = hist_q;
    db_d   = db_q;
    if (tick_i) begin
      hist_d = {hist_q[HIST_LEN-2:0], sync_q[1]};
      if (&hist_d) begin
        db_d = 1'b1;
      end else if (~|hist_d) begin
        db_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= '0;
      hist_q <= '0;
      db_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], in_i};
      hist_q <= hist_d;
      db_q   <= db_d;
    end
  end

  assign db_o  = db_q;
  assign chg_o = db_d ^ db_q;

endmodule

// File: rtl/pcihellocore_button_ctrl.sv
// pcihellocore_button_ctrl
//   Avalon-MM slave for the board button/switch port: debounces up to 32 raw
//   inputs, latches per-bit changes in a sticky EDGE register and raises a
//   maskable level interrupt.
//   Build option: define PCIHELLOCORE_BUTTON_IRQ_EN to implement MASK and irq;
//   without it MASK reads 0, writes to it are ignored and irq is tied low.
//   clk        : system clock
//   reset      : synchronous active-high reset
//   address    : register word select (DATA, PERIOD, MASK, EDGE)
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data
//   in_port    : raw asynchronous inputs
//   readdata   : registered read data, one cycle after address
//   irq        : level interrupt, active-high
module pcihellocore_button_ctrl
  import pcihellocore_button_pkg::*;
#(
  parameter int unsigned          WIDTH      = 32,
  parameter logic [PERIOD_W-1:0]  PERIOD_RST = 16'd49999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic                wr_en;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                tick;
  logic [1:0]          tcnt_q, tcnt_d;
  logic                primed_q, primed_d;
  logic [WIDTH-1:0]    db_vec, db_chg;
  logic [WIDTH-1:0]    edge_q, edge_d, edge_clr;
  logic [WIDTH-1:0]    mask_val;
  logic [31:0]         rdata_q, rdata_d;

  assign wr_en = chipselect & ~write_n;
  assign tick  = (cnt_q == period_q);

  // Prescaler: a PERIOD write restarts the count so the new period is exact.
  always_comb begin
    period_d = period_q;
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    if (wr_en && (address == ADDR_PERIOD)) begin
      period_d = writedata[PERIOD_W-1:0];
      cnt_d    = '0;
    end
  end

  // Edges are suppressed until the histories have been filled with real
  // samples, so the power-up settle of DATA does not look like a press.
  always_comb begin
    tcnt_d   = tcnt_q;
    primed_d = primed_q;
    if (tick && !primed_q) begin
      if (tcnt_q == 2'(HIST_LEN - 1)) begin
        primed_d = 1'b1;
      end else begin
        tcnt_d = tcnt_q + 2'd1;
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pcihellocore_button_debounce u_db (
      .clk_i   (clk),
      .reset_i (reset),
      .tick_i  (tick),
      .in_i    (in_port[i]),
      .db_o    (db_vec[i]),
      .chg_o   (db_chg[i])
    );
  end

  // A new edge in the same cycle as its write-1-to-clear wins.
  always_comb begin
    edge_clr = '0;
    if (wr_en && (address == ADDR_EDGE)) begin
      edge_clr = writedata[WIDTH-1:0];
    end
    edge_d = (edge_q & ~edge_clr) | (db_chg & {WIDTH{primed_q}});
  end

`ifdef PCIHELLOCORE_BUTTON_IRQ_EN
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             irq_q, irq_d;

  always_comb begin
    mask_d = mask_q;
    if (wr_en && (address == ADDR_MASK)) begin
      mask_d = writedata[WIDTH-1:0];
    end
    irq_d = |(edge_q & mask_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

  assign mask_val = mask_q;
  assign irq      = irq_q;
`else
  assign mask_val = '0;
  assign irq      = 1'b0;
`endif

  always_comb begin
    rdata_d = '0;
    case (address)
      ADDR_DATA:   rdata_d[WIDTH-1:0]    = db_vec;
      ADDR_PERIOD: rdata_d[PERIOD_W-1:0] = period_q;
      ADDR_MASK:   rdata_d[WIDTH-1:0]    = mask_val;
      ADDR_EDGE:   rdata_d[WIDTH-1:0]    = edge_q;
      default:     rdata_d               = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      period_q <= PERIOD_RST;
      cnt_q    <= '0;
      tcnt_q   <= '0;
      primed_q <= 1'b0;
      edge_q   <= '0;
      rdata_q  <= '0;
    end else begin
      period_q <= period_d;
      cnt_q    <= cnt_d;
      tcnt_q   <= tcnt_d;
      primed_q <= primed_d;
      edge_q   <= edge_d;
      rdata_q  <= rdata_d;
    end
  end

  assign readdata = rdata_q;

endmodule
